// File: rtl/timer_bank.sv
// Multi-channel programmable interval timer: per-channel periodic/one-shot counting with
// shadowed terminal count, registered overflow pulse and sticky overflow flag.
module timer_bank #(
  parameter int WIDTH = 16,
  parameter int N_CH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         en_i,
  input  logic [N_CH-1:0]         start_i,
  input  logic [N_CH-1:0]         stop_i,
  input  logic [N_CH-1:0]         mode_i,
  input  logic [N_CH*WIDTH-1:0]   term_i,
  input  logic [N_CH-1:0]         clr_i,
  output logic [N_CH*WIDTH-1:0]   cnt_o,
  output logic [N_CH-1:0]         ovf_o,
  output logic [N_CH-1:0]         busy_o,
  output logic [N_CH-1:0]         sticky_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  genvar g;
  for (g = 0; g < N_CH; g++) begin : g_ch
    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_term;
    logic             r_mode;
    logic             r_ovf;
    logic             r_sticky;
    logic             r_busy;
    logic [WIDTH-1:0] w_term_in;
    logic [WIDTH-1:0] w_last;
    logic             w_at_last;
    logic             w_hit;

    assign w_term_in = term_i[g*WIDTH +: WIDTH];
    // term_r of zero wraps to all-ones here, which yields the full 2^WIDTH period
    assign w_last    = r_term - ONE;
    assign w_at_last = (r_cnt == w_last);
    assign w_hit     = (r_state == ST_RUN) && en_i[g] && w_at_last && !stop_i[g] && !start_i[g];

    // Channel state, count, shadow registers and registered flags
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state  <= ST_IDLE;
        r_cnt    <= ZERO;
        r_term   <= ZERO;
        r_mode   <= 1'b0;
        r_ovf    <= 1'b0;
        r_sticky <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        r_ovf    <= w_hit;
        r_sticky <= w_hit | (r_sticky & ~clr_i[g]);
        if (stop_i[g]) begin
          r_state <= ST_IDLE;
          r_cnt   <= ZERO;
          r_busy  <= 1'b0;
        end else if (start_i[g]) begin
          r_state <= ST_RUN;
          r_cnt   <= ZERO;
          r_term  <= w_term_in;
          r_mode  <= mode_i[g];
          r_busy  <= 1'b1;
        end else begin
          case (r_state)
            ST_RUN: begin
              if (en_i[g]) begin
                if (w_at_last) begin
                  r_cnt <= ZERO;
                  if (r_mode) begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                  end else begin
                    r_term <= w_term_in;
                  end
                end else begin
                  r_cnt <= r_cnt + ONE;
                end
              end else begin
                r_cnt <= r_cnt;
              end
            end
            ST_DONE: begin
              r_cnt  <= ZERO;
              r_busy <= 1'b0;
            end
            ST_IDLE: begin
              r_cnt  <= ZERO;
              r_busy <= 1'b0;
            end
            default: begin
              r_state <= ST_IDLE;
              r_cnt   <= ZERO;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign cnt_o[g*WIDTH +: WIDTH] = r_cnt;
    assign ovf_o[g]                = r_ovf;
    assign busy_o[g]               = r_busy;
    assign sticky_o[g]             = r_sticky;
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank (WIDTH=4, N_CH=4).
module tb_timer_bank;
  localparam int W = 4;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   en;
  logic [N-1:0]   start;
  logic [N-1:0]   stop;
  logic [N-1:0]   mode;
  logic [N*W-1:0] term;
  logic [N-1:0]   clr;
  logic [N*W-1:0] cnt;
  logic [N-1:0]   ovf;
  logic [N-1:0]   busy;
  logic [N-1:0]   sticky;

  int checks   = 0;
  int failures = 0;

  timer_bank #(.WIDTH(W), .N_CH(N)) dut (
    .clk(clk), .rst(rst), .en_i(en), .start_i(start), .stop_i(stop),
    .mode_i(mode), .term_i(term), .clr_i(clr),
    .cnt_o(cnt), .ovf_o(ovf), .busy_o(busy), .sticky_o(sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] cnt_ch(input int k);
    return cnt[k*W +: W];
  endfunction

  task automatic set_term(input int k, input logic [W-1:0] v);
    term[k*W +: W] = v;
  endtask

  task automatic start_ch(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  initial begin
    logic [N-1:0]   e_ovf;
    logic [N*W-1:0] e_cnt;
    int             per [N];

    rst = 1'b1; en = 4'h0; start = 4'h0; stop = 4'h0; mode = 4'h0;
    term = 16'h0000; clr = 4'h0;
    tick(); tick();
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_flags", {20'h0, ovf, busy, sticky}, 32'h0);
    rst = 1'b0;
    tick();

    // Reset asynchronously mid-run on ch0 at cnt=5
    set_term(0, 4'd8); en[0] = 1'b1;
    start_ch(0);
    chk("ch0_start_busy", 32'(busy[0]), 32'h1);
    repeat (5) tick();
    chk("ch0_cnt5", 32'(cnt_ch(0)), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(cnt), 32'h0);
    chk("async_rst_flags", {20'h0, ovf, busy, sticky}, 32'h0);
    #2 rst = 1'b0;
    en = 4'hF;
    repeat (3) tick();
    chk("post_rst_cnt", 32'(cnt), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    en = 4'h0;

    // Periodic ch1, term=4
    set_term(1, 4'd4); mode[1] = 1'b0; en[1] = 1'b1;
    start_ch(1);
    chk("per_c0_cnt", 32'(cnt_ch(1)), 32'd0);
    chk("per_c0_ovf", 32'(ovf[1]), 32'd0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("per_c%0d_cnt", c), 32'(cnt_ch(1)), 32'(c % 4));
      chk($sformatf("per_c%0d_ovf", c), 32'(ovf[1]), 32'((c % 4) == 0));
      chk($sformatf("per_c%0d_sticky", c), 32'(sticky[1]), 32'(c >= 4));
      chk($sformatf("per_c%0d_busy", c), 32'(busy[1]), 32'h1);
    end
    stop[1] = 1'b1; tick(); stop[1] = 1'b0;
    chk("per_stop_busy", 32'(busy[1]), 32'h0);
    chk("per_stop_cnt", 32'(cnt_ch(1)), 32'h0);
    chk("per_stop_sticky_hold", 32'(sticky[1]), 32'h1);
    clr[1] = 1'b1; tick(); clr[1] = 1'b0;
    chk("per_clr_sticky", 32'(sticky[1]), 32'h0);
    en[1] = 1'b0;

    // One-shot ch2, term=6, paused 3 cycles at cnt=2
    set_term(2, 4'd6); mode[2] = 1'b1; en[2] = 1'b1;
    start_ch(2);
    tick(); tick();
    chk("os_cnt2", 32'(cnt_ch(2)), 32'd2);
    en[2] = 1'b0;
    repeat (3) tick();
    chk("os_pause_cnt", 32'(cnt_ch(2)), 32'd2);
    chk("os_pause_busy", 32'(busy[2]), 32'h1);
    en[2] = 1'b1;
    repeat (3) tick();
    chk("os_c8_cnt", 32'(cnt_ch(2)), 32'd5);
    chk("os_c8_ovf", 32'(ovf[2]), 32'h0);
    tick();
    chk("os_c9_ovf", 32'(ovf[2]), 32'h1);
    chk("os_c9_busy", 32'(busy[2]), 32'h0);
    chk("os_c9_cnt", 32'(cnt_ch(2)), 32'h0);
    chk("os_c9_sticky", 32'(sticky[2]), 32'h1);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("os_done%0d_ovf", c), 32'(ovf[2]), 32'h0);
      chk($sformatf("os_done%0d_busy", c), 32'(busy[2]), 32'h0);
    end
    mode[2] = 1'b0;

    // Priority on ch0, term=3 periodic
    set_term(0, 4'd3); mode[0] = 1'b0; en[0] = 1'b1;
    start_ch(0);
    tick(); tick();
    chk("pri_cnt2", 32'(cnt_ch(0)), 32'd2);
    start[0] = 1'b1; stop[0] = 1'b1; tick(); start[0] = 1'b0; stop[0] = 1'b0;
    chk("pri_stop_ovf", 32'(ovf[0]), 32'h0);
    chk("pri_stop_busy", 32'(busy[0]), 32'h0);
    chk("pri_stop_cnt", 32'(cnt_ch(0)), 32'h0);
    start_ch(0);
    tick(); tick();
    start_ch(0);
    chk("pri_restart_ovf", 32'(ovf[0]), 32'h0);
    chk("pri_restart_cnt", 32'(cnt_ch(0)), 32'h0);
    chk("pri_restart_busy", 32'(busy[0]), 32'h1);
    tick(); tick();
    chk("pri_after_ovf0", 32'(ovf[0]), 32'h0);
    tick();
    chk("pri_after_ovf1", 32'(ovf[0]), 32'h1);
    stop[0] = 1'b1; tick(); stop[0] = 1'b0;

    // Shadowed terminal count on ch3
    set_term(3, 4'd5); mode[3] = 1'b0; en[3] = 1'b1;
    start_ch(3);
    tick(); tick();
    set_term(3, 4'd2);
    tick(); tick();
    chk("sh_c4_cnt", 32'(cnt_ch(3)), 32'd4);
    chk("sh_c4_ovf", 32'(ovf[3]), 32'h0);
    tick();
    chk("sh_c5_ovf", 32'(ovf[3]), 32'h1);
    tick();
    chk("sh_c6_ovf", 32'(ovf[3]), 32'h0);
    chk("sh_c6_cnt", 32'(cnt_ch(3)), 32'd1);
    tick();
    chk("sh_c7_ovf", 32'(ovf[3]), 32'h1);

    // term=0 gives period 16
    set_term(3, 4'd0);
    start_ch(3);
    for (int c = 1; c < 16; c++) begin
      tick();
      chk($sformatf("t0_c%0d_ovf", c), 32'(ovf[3]), 32'h0);
    end
    chk("t0_c15_cnt", 32'(cnt_ch(3)), 32'd15);
    tick();
    chk("t0_c16_ovf", 32'(ovf[3]), 32'h1);
    chk("t0_c16_cnt", 32'(cnt_ch(3)), 32'd0);

    // term=1 pulses every cycle
    set_term(3, 4'd1);
    start_ch(3);
    chk("t1_c0_ovf", 32'(ovf[3]), 32'h0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("t1_c%0d_ovf", c), 32'(ovf[3]), 32'h1);
    end
    stop[3] = 1'b1; tick(); stop[3] = 1'b0;

    // Sticky set wins over a simultaneous clear, then a later clear takes effect
    set_term(1, 4'd4); en[1] = 1'b1;
    start_ch(1);
    repeat (3) tick();
    chk("sc_c3_cnt", 32'(cnt_ch(1)), 32'd3);
    clr[1] = 1'b1;
    tick();
    chk("sc_c4_ovf", 32'(ovf[1]), 32'h1);
    chk("sc_c4_sticky", 32'(sticky[1]), 32'h1);
    tick();
    clr[1] = 1'b0;
    chk("sc_c5_sticky", 32'(sticky[1]), 32'h0);
    stop[1] = 1'b1; tick(); stop[1] = 1'b0;

    // All channels concurrently with terms 3,5,7,2
    stop = 4'hF; clr = 4'hF; tick(); stop = 4'h0; clr = 4'h0;
    per[0] = 3; per[1] = 5; per[2] = 7; per[3] = 2;
    for (int k = 0; k < N; k++) set_term(k, W'(per[k]));
    mode = 4'h0; en = 4'hF;
    start = 4'hF; tick(); start = 4'h0;
    chk("ind_c0_cnt", 32'(cnt), 32'h0);
    for (int c = 1; c <= 30; c++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        e_ovf[k]         = ((c % per[k]) == 0);
        e_cnt[k*W +: W]  = W'(c % per[k]);
      end
      chk($sformatf("ind_c%0d_ovf", c), 32'(ovf), 32'(e_ovf));
      chk($sformatf("ind_c%0d_cnt", c), 32'(cnt), 32'(e_cnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
